// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter4
//  Purpose  : Four-requester round-robin arbiter with grant hold and timeout
//             preemption. The winner is encoded as a one-hot grant plus a
//             2-bit index and a valid flag. Once granted, the owner keeps
//             the resource until it drops its request or is revoked after
//             MAX_HOLD cycles. Every release is followed by one dead cycle.
//  Ports    :
//    clk       in   1  rising-edge clock
//    rst       in   1  asynchronous, active-high reset
//    req       in   4  request vector, req[i] held high until done
//    gnt       out  4  one-hot grant, zero when no owner
//    gnt_id    out  2  binary index of the owner, zero when idle
//    gnt_valid out  1  high while a grant is active (equals |gnt)
//    timeout   out  1  one-cycle pulse on the cycle a grant is revoked
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16,  // 0 disables the timeout
  parameter int HOLD_W   = 8    // MAX_HOLD must fit in HOLD_W bits
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_GRANT = 1'b1;

  localparam logic [HOLD_W-1:0] c_CNT_SAT  = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] c_MAX_HOLD = HOLD_W'(MAX_HOLD);

  logic [0:0]        r_state;
  logic [1:0]        r_ptr;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [3:0]        r_gnt;
  logic [1:0]        r_gnt_id;
  logic              r_gnt_valid;
  logic              r_timeout;

  // Requests rotated so that bit 0 corresponds to the current ptr; the first
  // set bit of the rotated vector is the offset of the winner from ptr.
  logic [7:0] w_req_dbl;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic [1:0] w_winner;
  logic       w_owner_req;
  logic       w_expire;

  assign w_req_dbl = {req, req};
  assign w_rot     = w_req_dbl[r_ptr +: 4];

  always_comb begin
    w_off = 2'd0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else if (w_rot[3]) w_off = 2'd3;
  end

  assign w_winner    = r_ptr + w_off;
  assign w_owner_req = req[r_gnt_id];
  // The owner dropping its request takes precedence over expiry, so a
  // release coinciding with the limit is reported as a normal release.
  assign w_expire    = (MAX_HOLD != 0) && (r_hold_cnt == c_MAX_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_ptr       <= 2'd0;
      r_hold_cnt  <= '0;
      r_gnt       <= 4'b0000;
      r_gnt_id    <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_timeout <= 1'b0;
          if (req != 4'b0000) begin
            r_state     <= c_GRANT;
            r_gnt       <= 4'b0001 << w_winner;
            r_gnt_id    <= w_winner;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        c_GRANT: begin
          if (!w_owner_req || w_expire) begin
            // Release: the dead cycle in IDLE is the resource turnaround.
            r_state     <= c_IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_gnt_id + 2'd1;
            r_timeout   <= w_owner_req;
          end else begin
            r_timeout <= 1'b0;
            if (r_hold_cnt != c_CNT_SAT) begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire
